// File: rtl/result_collector.sv
// Collects the 2x2 results of the PE, 3x3 and 2x2 convolution engines at their fixed
// latencies, cross-checks the systolic results against the PE reference and pages them to the display.
module result_collector #(
    parameter int LAT_PE      = 40,
    parameter int LAT_3B3     = 8,
    parameter int LAT_2B2     = 12,
    parameter int CNT_W       = 8,
    parameter int PAGE_CYCLES = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] o00_pe,
    input  logic [7:0] o01_pe,
    input  logic [7:0] o10_pe,
    input  logic [7:0] o11_pe,
    input  logic [7:0] o00_3b3,
    input  logic [7:0] o01_3b3,
    input  logic [7:0] o10_3b3,
    input  logic [7:0] o11_3b3,
    input  logic [7:0] o00_2b2,
    input  logic [7:0] o01_2b2,
    input  logic [7:0] o10_2b2,
    input  logic [7:0] o11_2b2,
    output logic [7:0] d00,
    output logic [7:0] d01,
    output logic [7:0] d10,
    output logic [7:0] d11,
    output logic [1:0] page,
    output logic       valid,
    output logic       match_3b3,
    output logic       match_2b2,
    output logic       busy
);

    localparam int TMR_W = (PAGE_CYCLES > 1) ? $clog2(PAGE_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        CHECK,
        SHOW
    } state_t;

    state_t state;
    state_t state_next;

    logic [CNT_W-1:0] cnt;
    logic             flag_pe;
    logic             flag_3b3;
    logic             flag_2b2;
    logic [31:0]      cap_pe;
    logic [31:0]      cap_3b3;
    logic [31:0]      cap_2b2;
    logic [TMR_W-1:0] timer;
    logic [31:0]      disp;

    logic [31:0]      in_pe;
    logic [31:0]      in_3b3;
    logic [31:0]      in_2b2;
    logic             hit_pe;
    logic             hit_3b3;
    logic             hit_2b2;
    logic             all_done;
    logic             page_end;
    logic [1:0]       page_next;
    logic [31:0]      page_next_data;

    assign in_pe  = {o00_pe, o01_pe, o10_pe, o11_pe};
    assign in_3b3 = {o00_3b3, o01_3b3, o10_3b3, o11_3b3};
    assign in_2b2 = {o00_2b2, o01_2b2, o10_2b2, o11_2b2};

    assign hit_pe  = (state == RUN) && (cnt == CNT_W'(LAT_PE - 1));
    assign hit_3b3 = (state == RUN) && (cnt == CNT_W'(LAT_3B3 - 1));
    assign hit_2b2 = (state == RUN) && (cnt == CNT_W'(LAT_2B2 - 1));

    // The flag setting this cycle counts, so CHECK follows the last capture directly.
    assign all_done = (flag_pe  | hit_pe)
                    & (flag_3b3 | hit_3b3)
                    & (flag_2b2 | hit_2b2);

    assign page_end  = (timer == TMR_W'(PAGE_CYCLES - 1));
    assign page_next = (page == 2'd2) ? 2'd0 : page + 2'd1;

    assign {d00, d01, d10, d11} = disp;
    assign busy = (state == RUN) || (state == CHECK);

    always_comb begin
        page_next_data = cap_pe;
        case (page_next)
            2'd1:    page_next_data = cap_3b3;
            2'd2:    page_next_data = cap_2b2;
            default: page_next_data = cap_pe;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (all_done) state_next = CHECK;
            CHECK:   state_next = SHOW;
            SHOW:    if (start) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            flag_pe   <= 1'b0;
            flag_3b3  <= 1'b0;
            flag_2b2  <= 1'b0;
            cap_pe    <= '0;
            cap_3b3   <= '0;
            cap_2b2   <= '0;
            timer     <= '0;
            page      <= '0;
            disp      <= '0;
            valid     <= 1'b0;
            match_3b3 <= 1'b0;
            match_2b2 <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt      <= '0;
                        flag_pe  <= 1'b0;
                        flag_3b3 <= 1'b0;
                        flag_2b2 <= 1'b0;
                    end
                end
                RUN: begin
                    if (cnt != '1) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                    if (hit_pe) begin
                        cap_pe  <= in_pe;
                        flag_pe <= 1'b1;
                    end
                    if (hit_3b3) begin
                        cap_3b3  <= in_3b3;
                        flag_3b3 <= 1'b1;
                    end
                    if (hit_2b2) begin
                        cap_2b2  <= in_2b2;
                        flag_2b2 <= 1'b1;
                    end
                end
                CHECK: begin
                    match_3b3 <= (cap_3b3 == cap_pe);
                    match_2b2 <= (cap_2b2 == cap_pe);
                    valid     <= 1'b1;
                    page      <= 2'd0;
                    timer     <= '0;
                    disp      <= cap_pe;
                end
                SHOW: begin
                    // A restart takes priority over a page advance; the display freezes until the next CHECK.
                    if (start) begin
                        valid     <= 1'b0;
                        match_3b3 <= 1'b0;
                        match_2b2 <= 1'b0;
                        cnt       <= '0;
                        flag_pe   <= 1'b0;
                        flag_3b3  <= 1'b0;
                        flag_2b2  <= 1'b0;
                    end else if (page_end) begin
                        timer <= '0;
                        page  <= page_next;
                        disp  <= page_next_data;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_result_collector.sv
// Directed self-checking bench for result_collector with short latencies and a 4-cycle page dwell.
module tb_result_collector;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] o00_pe, o01_pe, o10_pe, o11_pe;
    logic [7:0] o00_3b3, o01_3b3, o10_3b3, o11_3b3;
    logic [7:0] o00_2b2, o01_2b2, o10_2b2, o11_2b2;
    logic [7:0] d00, d01, d10, d11;
    logic [1:0] page;
    logic       valid;
    logic       match_3b3;
    logic       match_2b2;
    logic       busy;
    logic [31:0] dv;

    int errors;
    int checks;

    assign dv = {d00, d01, d10, d11};

    result_collector #(
        .LAT_PE     (10),
        .LAT_3B3    (4),
        .LAT_2B2    (6),
        .CNT_W      (8),
        .PAGE_CYCLES(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .o00_pe   (o00_pe),
        .o01_pe   (o01_pe),
        .o10_pe   (o10_pe),
        .o11_pe   (o11_pe),
        .o00_3b3  (o00_3b3),
        .o01_3b3  (o01_3b3),
        .o10_3b3  (o10_3b3),
        .o11_3b3  (o11_3b3),
        .o00_2b2  (o00_2b2),
        .o01_2b2  (o01_2b2),
        .o10_2b2  (o10_2b2),
        .o11_2b2  (o11_2b2),
        .d00      (d00),
        .d01      (d01),
        .d10      (d10),
        .d11      (d11),
        .page     (page),
        .valid    (valid),
        .match_3b3(match_3b3),
        .match_2b2(match_2b2),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic set_pe(input logic [31:0] v);
        {o00_pe, o01_pe, o10_pe, o11_pe} = v;
    endtask

    task automatic set_3b3(input logic [31:0] v);
        {o00_3b3, o01_3b3, o10_3b3, o11_3b3} = v;
    endtask

    task automatic set_2b2(input logic [31:0] v);
        {o00_2b2, o01_2b2, o10_2b2, o11_2b2} = v;
    endtask

    task automatic set_all(input logic [31:0] v);
        set_pe(v);
        set_3b3(v);
        set_2b2(v);
    endtask

    // Leaves the bench at the negedge of RUN cycle 0 (cnt == 0).
    task automatic do_start;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    // Steps until busy drops (first SHOW cycle), bounded.
    task automatic wait_idle(output int n);
        n = 0;
        for (int i = 0; i < 60 && busy; i++) begin
            n++;
            tick(1);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        checks++;
        if ({dv, page, valid, match_3b3, match_2b2, busy} !== 38'd0) begin
            errors++;
            $display("FAIL reset_state: got d=%h page=%0d valid=%b m3=%b m2=%b busy=%b required all zero",
                     dv, page, valid, match_3b3, match_2b2, busy);
        end
        tick(2);
        rst = 1'b0;
        tick(3);
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b valid=%b required 0 0", busy, valid);
        end
    endtask

    task automatic test_matching_run;
        int n;
        set_all(32'h12345678);
        do_start;
        wait_idle(n);
        checks++;
        if (n !== 11) begin
            errors++;
            $display("FAIL match_busy_len: got %0d required 11", n);
        end
        checks++;
        if ({valid, match_3b3, match_2b2, page} !== 5'b111_00) begin
            errors++;
            $display("FAIL match_flags: got valid=%b m3=%b m2=%b page=%0d required 1 1 1 0",
                     valid, match_3b3, match_2b2, page);
        end
        checks++;
        if (dv !== 32'h12345678) begin
            errors++;
            $display("FAIL match_page0_data: got %h required 12345678", dv);
        end
    endtask

    task automatic test_mismatch;
        int n;
        set_all(32'h12345678);
        do_start;
        tick(5);
        o11_2b2 = 8'h79;
        tick(1);
        o11_2b2 = 8'h78;
        wait_idle(n);
        checks++;
        if ({valid, match_3b3, match_2b2} !== 3'b110) begin
            errors++;
            $display("FAIL mismatch_flags: got valid=%b m3=%b m2=%b required 1 1 0",
                     valid, match_3b3, match_2b2);
        end
        tick(8);
        checks++;
        if (page !== 2'd2 || dv !== 32'h12345679) begin
            errors++;
            $display("FAIL mismatch_page2: got page=%0d d=%h required page=2 d=12345679", page, dv);
        end
    endtask

    task automatic test_page_rotation;
        int n;
        logic [31:0] exp_d [3];
        logic [1:0]  exp_p;
        exp_d[0] = 32'hA0A1A2A3;
        exp_d[1] = 32'hB0B1B2B3;
        exp_d[2] = 32'hC0C1C2C3;
        set_pe(exp_d[0]);
        set_3b3(exp_d[1]);
        set_2b2(exp_d[2]);
        do_start;
        wait_idle(n);
        checks++;
        if ({valid, match_3b3, match_2b2} !== 3'b100) begin
            errors++;
            $display("FAIL rot_flags: got valid=%b m3=%b m2=%b required 1 0 0", valid, match_3b3, match_2b2);
        end
        for (int i = 0; i < 13; i++) begin
            exp_p = 2'((i / 4) % 3);
            checks++;
            if (page !== exp_p || dv !== exp_d[exp_p]) begin
                errors++;
                $display("FAIL rot_cycle%0d: got page=%0d d=%h required page=%0d d=%h",
                         i, page, dv, exp_p, exp_d[exp_p]);
            end
            tick(1);
        end
    endtask

    task automatic test_restart_in_show;
        int n;
        set_pe(32'h11111111);
        set_3b3(32'h22222222);
        set_2b2(32'h33333333);
        do_start;
        wait_idle(n);
        tick(3);
        // Last cycle of page 0: the start edge would otherwise advance to page 1.
        do_start;
        checks++;
        if (page !== 2'd0 || dv !== 32'h11111111) begin
            errors++;
            $display("FAIL restart_hold: got page=%0d d=%h required page=0 d=11111111", page, dv);
        end
        checks++;
        if ({valid, match_3b3, match_2b2, busy} !== 4'b0001) begin
            errors++;
            $display("FAIL restart_clear: got valid=%b m3=%b m2=%b busy=%b required 0 0 0 1",
                     valid, match_3b3, match_2b2, busy);
        end
        set_all(32'h0F0E0D0C);
        set_3b3(32'h44444444);
        wait_idle(n);
        checks++;
        if (n !== 11 || dv !== 32'h0F0E0D0C || {valid, match_3b3, match_2b2} !== 3'b101) begin
            errors++;
            $display("FAIL restart_fresh: got len=%0d d=%h valid=%b m3=%b m2=%b required 11 0f0e0d0c 1 0 1",
                     n, dv, valid, match_3b3, match_2b2);
        end
        tick(4);
        checks++;
        if (page !== 2'd1 || dv !== 32'h44444444) begin
            errors++;
            $display("FAIL restart_page1: got page=%0d d=%h required page=1 d=44444444", page, dv);
        end
    endtask

    task automatic test_capture_timing;
        int n;
        set_pe(32'h01010101);
        set_3b3(32'h01010101);
        set_2b2(32'h77777777);
        do_start;
        tick(4);
        set_3b3(32'h99999999);
        tick(1);
        set_2b2(32'h01010101);
        tick(1);
        set_2b2(32'h55555555);
        tick(4);
        set_pe(32'h02020202);
        wait_idle(n);
        checks++;
        if (dv !== 32'h01010101) begin
            errors++;
            $display("FAIL capture_pe: got %h required 01010101", dv);
        end
        checks++;
        if (match_3b3 !== 1'b1 || match_2b2 !== 1'b1) begin
            errors++;
            $display("FAIL capture_window: got m3=%b m2=%b required 1 1", match_3b3, match_2b2);
        end
    endtask

    task automatic test_start_in_run;
        int n;
        set_all(32'h12345678);
        do_start;
        n = 0;
        for (int i = 0; i < 60 && busy; i++) begin
            n++;
            start = (n == 4);
            tick(1);
        end
        start = 1'b0;
        checks++;
        if (n !== 11 || valid !== 1'b1) begin
            errors++;
            $display("FAIL start_in_run: got len=%0d valid=%b required 11 1", n, valid);
        end
    endtask

    task automatic test_reset_midrun;
        bit seen_busy;
        set_all(32'h5A5A5A5A);
        do_start;
        tick(5);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({dv, page, valid, match_3b3, match_2b2, busy} !== 38'd0) begin
            errors++;
            $display("FAIL reset_midrun: got d=%h page=%0d valid=%b m3=%b m2=%b busy=%b required all zero",
                     dv, page, valid, match_3b3, match_2b2, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        seen_busy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (busy || valid) seen_busy = 1'b1;
            tick(1);
        end
        checks++;
        if (seen_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_stays_idle: got activity=%b required 0", seen_busy);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        start  = 1'b0;
        set_all(32'h0);
        test_reset;
        test_matching_run;
        test_mismatch;
        test_page_rotation;
        test_restart_in_show;
        test_capture_timing;
        test_start_in_run;
        test_reset_midrun;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
